descriptor_arbiter: RTL
=======================

Name: descriptor_arbiter

Overview:
- Merges the left and right descriptor streams onto one shared, back-pressured descriptor bus. Each stream carries a 32-bit keypoint, four 16-bit channels and a done flag.
- Sits between the two descriptor units and the single matcher port.
- Buffers each side in its own FIFO and grants the output slot round-robin.
- Tags each word with its source side and issues one frame-complete pulse after both sides have finished and all buffered words have drained.

Parameters:
- DEPTH, 8, entries per side FIFO; power of two, minimum 2.
- ADDR_W, 3, log2(DEPTH).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- l_valid  in  1  left descriptor word present this cycle.
- l_keypoint  in  32  left keypoint value.
- l_channels  in  64  left channels, packed as {ch1,ch2,ch3,ch4}.
- l_done  in  1  left descriptor unit finished its frame; level or pulse.
- r_valid  in  1  right descriptor word present this cycle.
- r_keypoint  in  32  right keypoint value.
- r_channels  in  64  right channels, packed as {ch1,ch2,ch3,ch4}.
- r_done  in  1  right descriptor unit finished its frame; level or pulse.
- m_ready  in  1  consumer accepts the current output word.
- m_valid  out  1  output word valid.
- m_side  out  1  source of the output word: 0 = left, 1 = right.
- m_keypoint  out  32  output keypoint.
- m_channels  out  64  output channels.
- m_done  out  1  one-cycle frame-complete pulse.
- l_overflow  out  1  sticky: a left word was dropped.
- r_overflow  out  1  sticky: a right word was dropped.

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0, both FIFOs empty, last_grant=1 (right), done flags cleared, state IDLE. Reset mid-operation discards all buffered data and any pending m_done.
- FIFO entry: 96 bits, {keypoint, channels}. Occupancy counter is ADDR_W+1 bits wide. Read/write pointers wrap modulo DEPTH.
- Push: a side's word is written when its valid=1 and (count<DEPTH or that FIFO is popped in the same cycle).
- Full with no pop: the word is dropped and that side's overflow flag sets. Overflow flags clear only on reset.
- Output slot: a single register stage. The slot is free when m_valid=0 or (m_valid & m_ready).
- Loading the slot: when the slot is free and at least one FIFO is non-empty, pop one FIFO into it the same edge and set m_valid=1 and m_side.
- Slot free, both FIFOs empty: m_valid goes 0.
- Back-pressure: while m_valid=1 and m_ready=0, m_side/m_keypoint/m_channels hold stable.
- Grant rule:
  - Only one side non-empty: that side wins.
  - Both non-empty: the side opposite last_grant wins, so left wins first after reset.
  - last_grant updates on every pop.
- Latency: a word pushed into an empty FIFO with a free slot appears on m_valid two cycles after its valid cycle. Sustained throughput is 1 word/cycle with m_ready held high.
- Done tracking: l_done_seen and r_done_seen are sticky; each sets when its done input is 1. A valid and a done in the same cycle means the word is accepted and the done counted.
- State machine:
  - IDLE: neither done seen. Goes to WAIT on the first done, or directly to DRAIN if both dones arrive in the same cycle.
  - WAIT: exactly one done seen. Goes to DRAIN when the other arrives.
  - DRAIN: both seen. Goes to FINISH when both FIFOs are empty and (m_valid=0, or m_valid & m_ready this cycle).
  - FINISH: m_done=1 for exactly one cycle; clear both done_seen flags; go to IDLE.
- Words arriving after the done of their side are still buffered and delivered. If DRAIN is active they extend the drain.
- Done inputs seen while in FINISH are ignored.
- m_done is never asserted with a word of the finished frame still pending.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles, all inputs 0 → every output 0 for 10 cycles after release.
- Single stream: left pushes keypoints 0x00010001..0x00010004 on consecutive cycles, m_ready=1 → m_valid first high 2 cycles after the first push; words emerge in order with m_side=0; no gaps.
- Interleave: both sides push 4 words simultaneously, m_ready=1 → output side order is 0,1,0,1,0,1,0,1; keypoints in per-side order.
- Back-pressure and overflow: m_ready=0, left pushes 10 words with DEPTH=8 → the slot holds word 0, the FIFO holds words 1–8, word 9 is dropped and l_overflow=1. Release m_ready → exactly 9 words delivered, and l_overflow stays 1.
- Done ordering: r_done pulses at cycle 5 while right words remain; l_done pulses at cycle 9 → m_done is a single one-cycle pulse on the cycle after the final handshake, never earlier.
- Reset mid-drain: assert rst_n=0 while 3 words are buffered and state is DRAIN → next cycle m_valid=0 and m_done=0; no stale words delivered after release.

Source files
------------

// File: rtl/descriptor_arbiter.sv
// descriptor_arbiter
//   Merges the left and right descriptor streams onto one back-pressured
//   descriptor bus. Each side is buffered in its own FIFO. The single output
//   slot is granted round-robin, and each word is tagged with its source side.
//   One m_done pulse is issued after both sides report done and every buffered
//   word has been handed off.
//
// Ports
//   clk, rst_n                   clock, synchronous active-low reset
//   l_valid/l_keypoint/l_channels/l_done   left descriptor stream
//   r_valid/r_keypoint/r_channels/r_done   right descriptor stream
//   m_ready                      consumer accepts the current output word
//   m_valid/m_side/m_keypoint/m_channels   output word (side 0=left, 1=right)
//   m_done                       one-cycle frame-complete pulse
//   l_overflow, r_overflow       sticky per-side drop flags

// Per-side FIFO. Holds {keypoint, channels}. A push into a full FIFO is
// accepted only when the same cycle also pops. Otherwise the word is dropped
// and the overflow flag is set.
module descriptor_fifo #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [95:0] data,
    input  logic        pop,
    output logic        empty,
    output logic [95:0] head,
    output logic        overflow
);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [95:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && ((count != FULL_CNT) || do_pop);

    // Storage carries no reset. Only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !do_push)
                overflow <= 1'b1;
        end
    end
endmodule

module descriptor_arbiter #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        l_valid,
    input  logic [31:0] l_keypoint,
    input  logic [63:0] l_channels,
    input  logic        l_done,
    input  logic        r_valid,
    input  logic [31:0] r_keypoint,
    input  logic [63:0] r_channels,
    input  logic        r_done,
    input  logic        m_ready,
    output logic        m_valid,
    output logic        m_side,
    output logic [31:0] m_keypoint,
    output logic [63:0] m_channels,
    output logic        m_done,
    output logic        l_overflow,
    output logic        r_overflow
);
    typedef struct packed {
        logic [31:0] keypoint;
        logic [63:0] channels;
    } desc_t;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DRAIN, ST_FINISH} state_t;

    // Index 0 = left, 1 = right, so the side index is also the m_side tag.
    logic  [1:0] side_valid;
    logic  [1:0] side_pop;
    logic  [1:0] side_empty;
    logic  [1:0] side_ovf;
    desc_t [1:0] side_in;
    desc_t [1:0] side_head;

    assign side_valid = {r_valid, l_valid};
    assign side_in[0] = {l_keypoint, l_channels};
    assign side_in[1] = {r_keypoint, r_channels};

    for (genvar g = 0; g < 2; g++) begin : g_side
        descriptor_fifo #(
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_fifo (
            .clk      (clk),
            .rst_n    (rst_n),
            .push     (side_valid[g]),
            .data     (side_in[g]),
            .pop      (side_pop[g]),
            .empty    (side_empty[g]),
            .head     (side_head[g]),
            .overflow (side_ovf[g])
        );
    end

    assign l_overflow = side_ovf[0];
    assign r_overflow = side_ovf[1];

    // Output slot and round-robin grant.
    logic last_grant;
    logic slot_free;
    logic grant_right;
    logic load;

    assign slot_free = !m_valid || m_ready;
    // Right wins when it is the only non-empty side, or when both are non-empty
    // and left had the last grant.
    assign grant_right = !side_empty[1] && (side_empty[0] || !last_grant);
    assign load        = slot_free && !(&side_empty);
    assign side_pop    = {load && grant_right, load && !grant_right};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid    <= 1'b0;
            m_side     <= 1'b0;
            m_keypoint <= '0;
            m_channels <= '0;
            last_grant <= 1'b1;
        end else if (slot_free) begin
            if (load) begin
                m_valid                  <= 1'b1;
                m_side                   <= grant_right;
                {m_keypoint, m_channels} <= side_head[grant_right];
                last_grant               <= grant_right;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

    // Frame-done tracking.
    state_t state;
    logic   l_done_seen;
    logic   r_done_seen;
    logic   l_seen_nx;
    logic   r_seen_nx;

    assign l_seen_nx = l_done_seen || l_done;
    assign r_seen_nx = r_done_seen || r_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            l_done_seen <= 1'b0;
            r_done_seen <= 1'b0;
            m_done      <= 1'b0;
        end else begin
            m_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    l_done_seen <= l_seen_nx;
                    r_done_seen <= r_seen_nx;
                    if (l_seen_nx && r_seen_nx)
                        state <= ST_DRAIN;
                    else if (l_seen_nx || r_seen_nx)
                        state <= ST_WAIT;
                end
                ST_WAIT: begin
                    l_done_seen <= l_seen_nx;
                    r_done_seen <= r_seen_nx;
                    if (l_seen_nx && r_seen_nx)
                        state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // The last pending word leaves on this edge, or the slot is already empty.
                    if ((&side_empty) && slot_free) begin
                        state  <= ST_FINISH;
                        m_done <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    // Any done input seen in this cycle is deliberately dropped.
                    l_done_seen <= 1'b0;
                    r_done_seen <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
